// File: rtl/pipe_stage_skid.sv
// Generic pipeline stage register with a 2-entry skid buffer, flush and occupancy view.
// Optional stall/flush statistics counters are compiled in with PIPE_STAGE_STATS_EN.
//
// state   | meaning
// S_EMPTY | no live entry, out_data_o = BUBBLE_VAL
// S_ONE   | main holds one live entry
// S_FULL  | main and skid both live, upstream stalled
module pipe_stage_skid #(
    parameter int                 WIDTH      = 32,
    parameter logic [WIDTH-1:0]   BUBBLE_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_data_o,
    output logic [1:0]       occupancy_o,
    output logic [31:0]      stall_cycles_o,
    output logic [15:0]      flush_count_o
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_main;
    logic [WIDTH-1:0] r_skid;
    logic             r_in_ready;
    logic             r_out_valid;
    logic [1:0]       r_occ;

    logic w_accept;
    logic w_pop;

    assign w_accept = in_valid_i & r_in_ready;
    assign w_pop    = r_out_valid & out_ready_i;

    // Handshake outputs are kept as flops alongside the state so no combinational
    // path from out_ready_i reaches in_ready_o.
    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            r_state     <= S_EMPTY;
            r_main      <= BUBBLE_VAL;
            r_skid      <= BUBBLE_VAL;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_occ       <= 2'd0;
        end else begin
            case (r_state)
                S_EMPTY: begin
                    if (w_accept) begin
                        r_state     <= S_ONE;
                        r_main      <= in_data_i;
                        r_out_valid <= 1'b1;
                        r_occ       <= 2'd1;
                    end
                end
                S_ONE: begin
                    if (w_accept && w_pop) begin
                        r_main <= in_data_i;
                    end else if (w_accept) begin
                        r_state    <= S_FULL;
                        r_skid     <= in_data_i;
                        r_in_ready <= 1'b0;
                        r_occ      <= 2'd2;
                    end else if (w_pop) begin
                        r_state     <= S_EMPTY;
                        r_main      <= BUBBLE_VAL;
                        r_out_valid <= 1'b0;
                        r_occ       <= 2'd0;
                    end
                end
                S_FULL: begin
                    if (w_pop) begin
                        r_state    <= S_ONE;
                        r_main     <= r_skid;
                        r_skid     <= BUBBLE_VAL;
                        r_in_ready <= 1'b1;
                        r_occ      <= 2'd1;
                    end
                end
                default: begin
                    r_state     <= S_EMPTY;
                    r_main      <= BUBBLE_VAL;
                    r_skid      <= BUBBLE_VAL;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                    r_occ       <= 2'd0;
                end
            endcase
        end
    end

    assign in_ready_o  = r_in_ready;
    assign out_valid_o = r_out_valid;
    assign out_data_o  = r_main;
    assign occupancy_o = r_occ;

`ifdef PIPE_STAGE_STATS_EN
    logic [31:0] r_stall_cycles;
    logic [15:0] r_flush_count;

    // Counters saturate and are cleared only by reset, never by flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cycles <= 32'd0;
            r_flush_count  <= 16'd0;
        end else begin
            if (r_out_valid && !out_ready_i && (r_stall_cycles != 32'hFFFF_FFFF)) begin
                r_stall_cycles <= r_stall_cycles + 32'd1;
            end
            if (flush_i && (r_flush_count != 16'hFFFF)) begin
                r_flush_count <= r_flush_count + 16'd1;
            end
        end
    end

    assign stall_cycles_o = r_stall_cycles;
    assign flush_count_o  = r_flush_count;
`else
    assign stall_cycles_o = 32'd0;
    assign flush_count_o  = 16'd0;
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Scoreboard bench for pipe_stage_skid: driver pushes accepted payloads, negedge monitor
// checks handshake, data order and statistics against a 2-deep queue model.
module tb_pipe_stage_skid;

    localparam int            W      = 16;
    localparam logic [W-1:0]  BUBBLE = '1;

    logic         clk = 1'b0;
    logic         rst;
    logic         flush_i;
    logic         in_valid_i;
    logic         in_ready_o;
    logic [W-1:0] in_data_i;
    logic         out_valid_o;
    logic         out_ready_i;
    logic [W-1:0] out_data_o;
    logic [1:0]   occupancy_o;
    logic [31:0]  stall_cycles_o;
    logic [15:0]  flush_count_o;

    pipe_stage_skid #(.WIDTH(W), .BUBBLE_VAL(BUBBLE)) dut (
        .clk            (clk),
        .rst            (rst),
        .flush_i        (flush_i),
        .in_valid_i     (in_valid_i),
        .in_ready_o     (in_ready_o),
        .in_data_i      (in_data_i),
        .out_valid_o    (out_valid_o),
        .out_ready_i    (out_ready_i),
        .out_data_o     (out_data_o),
        .occupancy_o    (occupancy_o),
        .stall_cycles_o (stall_cycles_o),
        .flush_count_o  (flush_count_o)
    );

    always #5 clk = ~clk;

    logic [W-1:0] exp_q[$];
    int           pend = 0;
    bit           mon_en = 1'b0;
    int           checks = 0;
    int           errors = 0;
    logic [31:0]  m_stall = 0;
    logic [15:0]  m_flush = 0;
    int           accepted = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // One cycle of stimulus; the payload joins the expected stream only if the model accepts it.
    task automatic drive(input logic v, input logic [W-1:0] d, input logic r,
                         input logic f, input logic rs);
        @(posedge clk);
        #2;
        in_valid_i  = v;
        in_data_i   = d;
        out_ready_i = r;
        flush_i     = f;
        rst         = rs;
        pend        = 0;
        if (!rs && !f && v && exp_q.size() < 2) begin
            exp_q.push_back(d);
            pend = 1;
            accepted++;
        end
    endtask

    always @(negedge clk) begin
        int n;
        if (mon_en) begin
            n = exp_q.size() - pend;
            chk("out_valid", {31'd0, out_valid_o}, {31'd0, n > 0});
            chk("in_ready", {31'd0, in_ready_o}, {31'd0, n < 2});
            chk("occupancy", {30'd0, occupancy_o}, n);
            chk("out_data", {16'd0, out_data_o}, {16'd0, (n > 0) ? exp_q[0] : BUBBLE});
`ifdef PIPE_STAGE_STATS_EN
            chk("stall_cycles", stall_cycles_o, m_stall);
            chk("flush_count", {16'd0, flush_count_o}, {16'd0, m_flush});
`else
            chk("stall_cycles", stall_cycles_o, 32'd0);
            chk("flush_count", {16'd0, flush_count_o}, 32'd0);
`endif
            if (rst) begin
                exp_q.delete();
                m_stall = 0;
                m_flush = 0;
            end else begin
                if (n > 0 && !out_ready_i && m_stall != 32'hFFFF_FFFF) m_stall++;
                if (flush_i && m_flush != 16'hFFFF) m_flush++;
                if (n > 0 && out_ready_i) void'(exp_q.pop_front());
                if (flush_i) exp_q.delete();
            end
        end
    end

    initial begin
        rst = 1'b1; flush_i = 1'b0; in_valid_i = 1'b0; in_data_i = '0; out_ready_i = 1'b0;
        repeat (2) @(posedge clk);
        #2 mon_en = 1'b1;

        // streaming at full rate
        drive(1, 16'h0011, 1, 0, 0);
        drive(1, 16'h0022, 1, 0, 0);
        drive(1, 16'h0033, 1, 0, 0);
        drive(0, 16'h0000, 1, 0, 0);
        drive(0, 16'h0000, 1, 0, 0);

        // skid fill, held 0xC is refused until space frees up
        drive(1, 16'h000A, 0, 0, 0);
        drive(1, 16'h000B, 0, 0, 0);
        drive(1, 16'h000C, 0, 0, 0);
        drive(1, 16'h000C, 1, 0, 0);
        drive(1, 16'h000C, 1, 0, 0);
        drive(0, 16'h0000, 1, 0, 0);
        drive(0, 16'h0000, 1, 0, 0);

        // flush while FULL with a valid offer that must be dropped
        drive(1, 16'h00A1, 0, 0, 0);
        drive(1, 16'h00B1, 0, 0, 0);
        drive(1, 16'h000D, 0, 1, 0);
        drive(0, 16'h0000, 1, 0, 0);
        drive(0, 16'h0000, 1, 0, 0);

        // reset together with flush and valid while FULL
        drive(1, 16'h00A2, 0, 0, 0);
        drive(1, 16'h00B2, 0, 0, 0);
        drive(1, 16'h000E, 0, 1, 1);
        drive(0, 16'h0000, 1, 0, 0);

        // five cycles of backpressure on one live entry
        drive(1, 16'h0055, 0, 0, 0);
        repeat (5) drive(0, 16'h0000, 0, 0, 0);
        drive(0, 16'h0000, 1, 0, 0);
        @(negedge clk);
`ifdef PIPE_STAGE_STATS_EN
        chk("stall_after_hold", stall_cycles_o, 32'd5);
`else
        chk("stall_after_hold", stall_cycles_o, 32'd0);
`endif

        // randomized streaming with occasional flush/reset
        accepted = 0;
        for (int cyc = 0; cyc < 20000 && accepted < 1000; cyc++) begin
            drive(($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0, W'($urandom),
                  ($urandom_range(0, 9) < 6) ? 1'b1 : 1'b0,
                  ($urandom_range(0, 99) == 0) ? 1'b1 : 1'b0,
                  ($urandom_range(0, 299) == 0) ? 1'b1 : 1'b0);
        end
        chk("random_accepted", accepted >= 1000, 32'd1);

        // drain and confirm the model emptied with the DUT
        repeat (4) drive(0, 16'h0000, 1, 0, 0);
        @(negedge clk);
        chk("drained_queue", exp_q.size(), 32'd0);

        mon_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
- Parametrised successor to the fixed MEM/WB-style pipeline register: one generic stage register with a valid/ready handshake, a 2-entry skid buffer, flush (bubble injection) and a per-stage occupancy view.
- Instantiated between any two pipeline stages (IF/ID … MEM/WB). Lets the core stall on cache misses without a combinational ready path back through the pipe.
- The payload is an opaque packed vector: control word, PC, instruction, immediates and data concatenated by the instantiating stage.

Parameters:
- WIDTH, 32, payload width in bits (≥1).
- BUBBLE_VAL, '0 (WIDTH bits), payload value loaded on reset and on flush; a clean NOP control word.

Ports:
- clk  in  1  clock, all state updates on posedge.
- rst  in  1  synchronous active-high reset.
- flush_i  in  1  discard all held entries; inject bubble.
- in_valid_i  in  1  upstream payload valid.
- in_ready_o  out  1  stage can accept; driven from a register only.
- in_data_i  in  WIDTH  upstream payload.
- out_valid_o  out  1  out_data_o holds a live entry.
- out_ready_i  in  1  downstream consumes this cycle.
- out_data_o  out  WIDTH  main-entry payload.
- occupancy_o  out  2  live entries, 0..2.
- stall_cycles_o  out  32  see Optional Feature.
- flush_count_o  out  16  see Optional Feature.

Behaviour:
- Interface fixed: one clock, clk; reset rst, synchronous and active-high.
- Reset values: state EMPTY; main and skid data = BUBBLE_VAL; out_valid_o=0; in_ready_o=1; occupancy_o=0; counters 0.
- Definitions: accept = in_valid_i & in_ready_o; pop = out_valid_o & out_ready_i.
- in_ready_o = (state != FULL). out_valid_o = (state != EMPTY). occupancy_o: EMPTY=0, ONE=1, FULL=2.
- EMPTY: accept -> ONE, main<=in_data_i.
- ONE, accept & pop -> ONE, main<=in_data_i.
- ONE, accept & !pop -> FULL, skid<=in_data_i; main holds.
- ONE, !accept & pop -> EMPTY; main<=BUBBLE_VAL.
- ONE, otherwise: hold.
- FULL: no accept is possible. pop -> ONE, main<=skid, skid<=BUBBLE_VAL. Otherwise hold.
- Latency: 1 cycle from accept to out_valid_o.
- Throughput: 1 entry/cycle while out_ready_i=1.
- Ordering: strictly FIFO; no entry is lost or duplicated.
- out_data_o = main data always, and equals BUBBLE_VAL whenever state is EMPTY.
- flush_i: next state EMPTY and both data regs = BUBBLE_VAL.
  - The input offered in the flush cycle is dropped, even if accept was true.
  - A pop in the flush cycle still counts as consumed downstream.
- rst dominates flush_i. Reset asserted mid-stall or mid-FULL discards everything.
- Holding: while out_valid_o=1 & out_ready_i=0, out_data_o is stable.

Optional Feature:
- Macro PIPE_STAGE_STATS_EN.
- Defined:
  - stall_cycles_o increments each cycle with out_valid_o=1 & out_ready_i=0, saturating at 2^32-1.
  - flush_count_o increments on each cycle flush_i=1 while rst=0, saturating at 2^16-1.
  - Both are cleared by rst only.
- Undefined: no counter logic is compiled; both ports are tied to 0.

Test Plan:
- Stream: out_ready_i=1, push 0x11,0x22,0x33 on consecutive cycles -> out_data_o shows 0x11,0x22,0x33 one cycle later each; occupancy_o stays 1; in_ready_o never drops.
- Skid fill: push 0xA,0xB with out_ready_i=0 -> occupancy_o 1 then 2; in_ready_o=0 after 2nd accept; a 0xC held on input is not taken. Raise out_ready_i -> outputs 0xA, 0xB, then 0xC accepted.
- Flush in FULL with in_valid_i=1 (0xD): next cycle out_valid_o=0, occupancy_o=0, out_data_o=BUBBLE_VAL, in_ready_o=1; 0xD never appears at output.
- Reset mid-operation: in FULL assert rst together with flush_i and in_valid_i -> all reset values next cycle; flush_count_o stays 0.
- Backpressure hold: out_valid_o=1, out_ready_i=0 for 5 cycles -> out_data_o constant. With PIPE_STAGE_STATS_EN, stall_cycles_o=5; without it, stall_cycles_o=0.
- WIDTH=1 and WIDTH=128 builds with BUBBLE_VAL='1 -> reset and flush load all-ones; random valid/ready streaming of 1000 entries matches a reference queue.
